ctrl_pipeline: RTL and testbench

//  Consumer side of the ID-stage control decoder. Carries the 5-bit EX and MEM control bundles through
//  the ID/EX, EX/MEM and MEM/WB registers, and drives per-stage control strobes to the datapath.

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ctrl_stage_reg.sv | 46 ++++
 rtl/ctrl_pipeline.sv | 125 ++++++++++++
 tb/tb_ctrl_pipeline.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Control-bundle bit positions, widths and redirect helper
//                shared by the control pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam int CTRL_W  = 5;
    localparam int ALUOP_W = 3;

    localparam int EX_ALUOP_HI = 4;
    localparam int EX_ALUOP_LO = 2;
    localparam int EX_MEMREAD  = 1;
    localparam int EX_MEMWRITE = 0;

    localparam int MEM_REGWRITE = 4;
    localparam int MEM_MEMTOREG = 3;
    localparam int MEM_PCTOREG  = 2;
    localparam int MEM_BRANCH   = 1;
    localparam int MEM_JUMP     = 0;

    // True when the MEM-stage bundle changes the PC: a jump, or a branch whose
    // condition was captured as true on the way out of EX.
    function automatic logic takes_redirect(input logic [CTRL_W-1:0] mem_ctrl,
                                            input logic              br_q);
        return mem_ctrl[MEM_JUMP] | (mem_ctrl[MEM_BRANCH] & br_q);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
// ============================================================================
//  Module      : ctrl_stage_reg
//  Description : Valid + payload pipeline register with hold, bubble and clear.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_hold,
    input  logic         i_bubble,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Hold outranks bubble/load; clear drops the entry even while held.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (!i_hold) begin
            if (i_bubble) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= i_valid;
                r_data  <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ctrl_pipeline.sv
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : ID/EX, EX/MEM, MEM/WB control registers with load-use stall,
//                MEM-stage branch/jump redirect and memory-stall freeze.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ex_ctrl,
    input  logic [CTRL_W-1:0] id_mem_ctrl,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_br_cond,
    input  logic              mem_stall,
    output logic              id_stall,
    output logic              if_flush,
    output logic              redirect,
    output logic              ex_valid,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_pc_to_reg,
    output logic [REG_AW-1:0] wb_rd
);

    localparam int IDEX_W  = 2 * CTRL_W + REG_AW;
    localparam int EXMEM_W = 2 + CTRL_W + REG_AW + 1;
    localparam int MEMWB_W = 3 + REG_AW;

    logic               w_ex_valid;
    logic [IDEX_W-1:0]  w_idex_data;
    logic [CTRL_W-1:0]  w_ex_exc;
    logic [CTRL_W-1:0]  w_ex_memc;
    logic [REG_AW-1:0]  w_ex_rd;

    logic               w_mem_valid;
    logic [EXMEM_W-1:0] w_exmem_data;
    logic               w_mem_rd_en;
    logic               w_mem_wr_en;
    logic [CTRL_W-1:0]  w_mem_memc;
    logic [REG_AW-1:0]  w_mem_rd;
    logic               w_mem_br;

    logic               w_wb_valid;
    logic [MEMWB_W-1:0] w_memwb_data;

    logic               w_lu;
    logic               w_redirect;

    assign w_ex_exc  = w_idex_data[IDEX_W-1 -: CTRL_W];
    assign w_ex_memc = w_idex_data[REG_AW +: CTRL_W];
    assign w_ex_rd   = w_idex_data[REG_AW-1:0];

    assign {w_mem_rd_en, w_mem_wr_en, w_mem_memc, w_mem_rd, w_mem_br} = w_exmem_data;

    assign w_lu = w_ex_valid & w_ex_exc[EX_MEMREAD] & id_valid
                & ((w_ex_rd == id_rs) | (w_ex_rd == id_rt));

    assign w_redirect = w_mem_valid & takes_redirect(w_mem_memc, w_mem_br) & ~mem_stall;

    // A redirect discards the ID instruction, so a coincident load-use needs no stall.
    assign id_stall = mem_stall | (w_lu & ~w_redirect);
    assign if_flush = w_redirect;
    assign redirect = w_redirect;

    ctrl_stage_reg #(.W(IDEX_W)) u_id_ex (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (mem_stall),
        .i_bubble (w_redirect | w_lu),
        .i_clear  (1'b0),
        .i_valid  (id_valid),
        .i_data   ({id_ex_ctrl, id_mem_ctrl, id_rd}),
        .o_valid  (w_ex_valid),
        .o_data   (w_idex_data)
    );

    ctrl_stage_reg #(.W(EXMEM_W)) u_ex_mem (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (mem_stall),
        .i_bubble (1'b0),
        .i_clear  (w_redirect),
        .i_valid  (w_ex_valid),
        .i_data   ({w_ex_exc[EX_MEMREAD], w_ex_exc[EX_MEMWRITE], w_ex_memc, w_ex_rd, ex_br_cond}),
        .o_valid  (w_mem_valid),
        .o_data   (w_exmem_data)
    );

    ctrl_stage_reg #(.W(MEMWB_W)) u_mem_wb (
        .clk      (clk),
        .rst      (rst),
        .i_hold   (mem_stall),
        .i_bubble (1'b0),
        .i_clear  (1'b0),
        .i_valid  (w_mem_valid),
        .i_data   ({w_mem_memc[MEM_REGWRITE], w_mem_memc[MEM_MEMTOREG],
                    w_mem_memc[MEM_PCTOREG], w_mem_rd}),
        .o_valid  (w_wb_valid),
        .o_data   (w_memwb_data)
    );

    assign ex_valid      = w_ex_valid;
    assign ex_alu_op     = w_ex_valid ? w_ex_exc[EX_ALUOP_HI:EX_ALUOP_LO] : '0;
    assign mem_read      = w_mem_valid & w_mem_rd_en;
    assign mem_write     = w_mem_valid & w_mem_wr_en;
    assign wb_reg_write  = w_wb_valid & w_memwb_data[REG_AW+2];
    assign wb_mem_to_reg = w_wb_valid & w_memwb_data[REG_AW+1];
    assign wb_pc_to_reg  = w_wb_valid & w_memwb_data[REG_AW];
    assign wb_rd         = w_wb_valid ? w_memwb_data[REG_AW-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Directed scenarios plus randomized run against a stage model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_ex_ctrl;
    logic [4:0] id_mem_ctrl;
    logic [5:0] id_rd, id_rs, id_rt;
    logic       ex_br_cond;
    logic       mem_stall;
    logic       id_stall, if_flush, redirect, ex_valid;
    logic [2:0] ex_alu_op;
    logic       mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg;
    logic [5:0] wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ctrl_pipeline #(.REG_AW(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ex_ctrl    (id_ex_ctrl),
        .id_mem_ctrl   (id_mem_ctrl),
        .id_rd         (id_rd),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_br_cond    (ex_br_cond),
        .mem_stall     (mem_stall),
        .id_stall      (id_stall),
        .if_flush      (if_flush),
        .redirect      (redirect),
        .ex_valid      (ex_valid),
        .ex_alu_op     (ex_alu_op),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_pc_to_reg  (wb_pc_to_reg),
        .wb_rd         (wb_rd)
    );

    wire [17:0] w_outs = {id_stall, if_flush, redirect, ex_valid, ex_alu_op, mem_read,
                          mem_write, wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_rd};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        id_valid = 1'b0; id_ex_ctrl = '0; id_mem_ctrl = '0;
        id_rd = '0; id_rs = '0; id_rt = '0;
        ex_br_cond = 1'b0; mem_stall = 1'b0;
    endtask

    task automatic set_instr(input logic [4:0] exc, input logic [4:0] memc,
                             input logic [5:0] rd, input logic [5:0] rs, input logic [5:0] rt);
        id_valid = 1'b1; id_ex_ctrl = exc; id_mem_ctrl = memc;
        id_rd = rd; id_rs = rs; id_rt = rt;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (w_outs !== 18'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", w_outs);
        end
    endtask

    task automatic test_alu();
        drive_idle(); repeat (3) tick();
        set_instr(5'b00000, 5'b10000, 6'd5, 6'd1, 6'd2);
        tick();
        drive_idle(); #1;
        n_checks++;
        if (ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL alu_ex_valid: got %b want 1", ex_valid);
        end
        tick(); tick(); #1;
        n_checks++;
        if (wb_reg_write !== 1'b1 || wb_rd !== 6'd5) begin
            n_fail++; $display("FAIL alu_wb: got we=%b rd=%0d want we=1 rd=5", wb_reg_write, wb_rd);
        end
    endtask

    task automatic test_load_use();
        drive_idle(); repeat (3) tick();
        set_instr(5'b01110, 5'b11000, 6'd3, 6'd0, 6'd0);
        tick();
        set_instr(5'b00000, 5'b10000, 6'd7, 6'd3, 6'd4); #1;
        n_checks++;
        if (id_stall !== 1'b1 || ex_alu_op !== 3'b011) begin
            n_fail++; $display("FAIL lu_stall: got stall=%b op=%b want stall=1 op=011", id_stall, ex_alu_op);
        end
        tick(); #1;
        n_checks++;
        if ({ex_valid, mem_read, id_stall} !== 3'b010) begin
            n_fail++; $display("FAIL lu_bubble: got ev/mr/st=%b want 010", {ex_valid, mem_read, id_stall});
        end
        tick();
        drive_idle(); #1;
        n_checks++;
        if ({ex_valid, wb_reg_write, wb_mem_to_reg} !== 3'b111 || wb_rd !== 6'd3) begin
            n_fail++; $display("FAIL lu_load_wb: got %b rd=%0d want 111 rd=3",
                               {ex_valid, wb_reg_write, wb_mem_to_reg}, wb_rd);
        end
        tick(); tick(); #1;
        n_checks++;
        if (wb_reg_write !== 1'b1 || wb_rd !== 6'd7 || wb_mem_to_reg !== 1'b0) begin
            n_fail++; $display("FAIL lu_add_wb: got we=%b rd=%0d m2r=%b want 1 7 0",
                               wb_reg_write, wb_rd, wb_mem_to_reg);
        end
    endtask

    task automatic test_taken_branch();
        logic bad;
        bad = 1'b0;
        drive_idle(); repeat (3) tick();
        set_instr(5'b00000, 5'b00010, 6'd0, 6'd10, 6'd11);
        tick();
        set_instr(5'b00001, 5'b10000, 6'd8, 6'd12, 6'd13);
        ex_br_cond = 1'b1;
        tick();
        ex_br_cond = 1'b0;
        set_instr(5'b00001, 5'b10000, 6'd9, 6'd14, 6'd15); #1;
        bad = bad | mem_write | wb_reg_write;
        n_checks++;
        if ({redirect, if_flush, id_stall} !== 3'b110) begin
            n_fail++; $display("FAIL br_redirect: got rd/fl/st=%b want 110", {redirect, if_flush, id_stall});
        end
        tick();
        drive_idle(); #1;
        bad = bad | mem_write | wb_reg_write;
        n_checks++;
        if (redirect !== 1'b0 || ex_valid !== 1'b0) begin
            n_fail++; $display("FAIL br_one_cycle: got redirect=%b ex_valid=%b want 0 0", redirect, ex_valid);
        end
        repeat (3) begin
            tick();
            bad = bad | mem_write | wb_reg_write;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL br_wrong_path: got strobe=%b want 0", bad);
        end
    endtask

    task automatic test_untaken_branch();
        drive_idle(); repeat (3) tick();
        set_instr(5'b00000, 5'b00010, 6'd0, 6'd1, 6'd2);
        tick();
        set_instr(5'b00000, 5'b10000, 6'd12, 6'd1, 6'd2);
        tick();
        drive_idle(); #1;
        n_checks++;
        if (redirect !== 1'b0 || ex_valid !== 1'b1) begin
            n_fail++; $display("FAIL nbr_no_redirect: got redirect=%b ex_valid=%b want 0 1", redirect, ex_valid);
        end
        tick(); tick(); #1;
        n_checks++;
        if (wb_reg_write !== 1'b1 || wb_rd !== 6'd12) begin
            n_fail++; $display("FAIL nbr_follower_wb: got we=%b rd=%0d want 1 12", wb_reg_write, wb_rd);
        end
    endtask

    task automatic test_mem_stall();
        drive_idle(); repeat (3) tick();
        set_instr(5'b11101, 5'b00000, 6'd2, 6'd0, 6'd0);
        tick();
        set_instr(5'b00000, 5'b10101, 6'd31, 6'd2, 6'd2);
        tick();
        set_instr(5'b00000, 5'b10000, 6'd20, 6'd0, 6'd0);
        mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({mem_write, ex_valid, id_stall, redirect} !== 4'b1110) begin
                n_fail++; $display("FAIL stall_hold_%0d: got mw/ev/st/rd=%b want 1110", k,
                                   {mem_write, ex_valid, id_stall, redirect});
            end
            tick();
        end
        mem_stall = 1'b0; #1;
        n_checks++;
        if (id_stall !== 1'b0 || mem_write !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: got st=%b mw=%b want 0 1", id_stall, mem_write);
        end
        tick();
        drive_idle();
        mem_stall = 1'b1; #1;
        n_checks++;
        if (redirect !== 1'b0 || id_stall !== 1'b1) begin
            n_fail++; $display("FAIL stall_jump_held: got redirect=%b st=%b want 0 1", redirect, id_stall);
        end
        tick();
        mem_stall = 1'b0; #1;
        n_checks++;
        if (redirect !== 1'b1) begin
            n_fail++; $display("FAIL stall_jump_redirect: got %b want 1", redirect);
        end
        tick(); #1;
        n_checks++;
        if ({ex_valid, mem_read, mem_write, wb_reg_write, wb_pc_to_reg} !== 5'b00011 || wb_rd !== 6'd31) begin
            n_fail++; $display("FAIL stall_jump_wb: got %b rd=%0d want 00011 rd=31",
                               {ex_valid, mem_read, mem_write, wb_reg_write, wb_pc_to_reg}, wb_rd);
        end
        tick(); #1;
        n_checks++;
        if (wb_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL stall_killed_wb: got we=%b rd=%0d want 0", wb_reg_write, wb_rd);
        end
    endtask

    task automatic test_reset_midflight();
        logic bad;
        bad = 1'b0;
        drive_idle(); repeat (3) tick();
        set_instr(5'b00001, 5'b10000, 6'd1, 6'd0, 6'd0); tick();
        set_instr(5'b00010, 5'b10000, 6'd2, 6'd0, 6'd0); tick();
        set_instr(5'b00001, 5'b10000, 6'd3, 6'd0, 6'd0); tick();
        set_instr(5'b00000, 5'b10000, 6'd4, 6'd0, 6'd0); #1;
        n_checks++;
        if ({ex_valid, mem_read, wb_reg_write} !== 3'b111) begin
            n_fail++; $display("FAIL rst_preload: got %b want 111", {ex_valid, mem_read, wb_reg_write});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_idle(); #1;
        n_checks++;
        if (w_outs !== 18'd0) begin
            n_fail++; $display("FAIL rst_midflight: got %h want 0", w_outs);
        end
        repeat (3) begin
            tick();
            bad = bad | (|w_outs);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_writeback: got %b want 0", bad);
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [4:0] exc;
        logic [4:0] memc;
        logic [5:0] rd;
        logic       br;
    } ent_t;

    task automatic test_random();
        ent_t       m_ex, m_mem, m_wb;
        logic       lu, redir;
        logic [17:0] exp;
        drive_idle();
        rst = 1'b1; tick(); rst = 1'b0;
        m_ex = '0; m_mem = '0; m_wb = '0;
        for (int i = 0; i < 600; i++) begin
            id_valid    = 1'($urandom_range(0, 1));
            id_ex_ctrl  = 5'($urandom_range(0, 31));
            id_mem_ctrl = 5'($urandom_range(0, 31));
            id_rd       = 6'($urandom_range(0, 3));
            id_rs       = 6'($urandom_range(0, 3));
            id_rt       = 6'($urandom_range(0, 3));
            ex_br_cond  = 1'($urandom_range(0, 1));
            mem_stall   = ($urandom_range(0, 4) == 0);
            rst         = ($urandom_range(0, 59) == 0);
            #1;
            lu    = m_ex.v && m_ex.exc[1] && id_valid && (m_ex.rd == id_rs || m_ex.rd == id_rt);
            redir = m_mem.v && (m_mem.memc[0] || (m_mem.memc[1] && m_mem.br)) && !mem_stall;
            exp = {mem_stall | (lu & ~redir), redir, redir, m_ex.v,
                   m_ex.v ? m_ex.exc[4:2] : 3'b000,
                   m_mem.v & m_mem.exc[1], m_mem.v & m_mem.exc[0],
                   m_wb.v & m_wb.memc[4], m_wb.v & m_wb.memc[3], m_wb.v & m_wb.memc[2],
                   m_wb.v ? m_wb.rd : 6'd0};
            n_checks++;
            if (w_outs !== exp) begin
                n_fail++; $display("FAIL rand_cycle_%0d: got %b want %b", i, w_outs, exp);
            end
            if (rst) begin
                m_ex = '0; m_mem = '0; m_wb = '0;
            end else if (!mem_stall) begin
                m_wb  = m_mem;
                m_mem = redir ? '0 : m_ex;
                if (!redir) m_mem.br = ex_br_cond;
                if (id_valid && !redir && !lu)
                    m_ex = '{v: 1'b1, exc: id_ex_ctrl, memc: id_mem_ctrl, rd: id_rd, br: 1'b0};
                else
                    m_ex = '0;
            end
            tick();
        end
        rst = 1'b0;
        drive_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        tick();
        test_reset();
        test_alu();
        test_load_use();
        test_taken_branch();
        test_untaken_branch();
        test_mem_stall();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
